// File: rtl/lx32_regfile.sv
// lx32_regfile: LX32 integer register file with one write port and two registered read ports.
// x0 is hard-wired to zero.
// Define LX32_REGFILE_BYPASS_EN to forward a same-edge write to a colliding read.
module lx32_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            re_a,
  input  logic [AW-1:0]   raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic            re_b,
  input  logic [AW-1:0]   raddr_b,
  output logic [XLEN-1:0] rdata_b
);
  logic [XLEN-1:0] mem [NREGS];
  logic [XLEN-1:0] rd_a, rd_b;
  logic            wr;
  assign wr = we && waddr != '0;
`ifdef LX32_REGFILE_BYPASS_EN
  assign rd_a = raddr_a == '0 ? '0 : (wr && raddr_a == waddr) ? wdata : mem[raddr_a];
  assign rd_b = raddr_b == '0 ? '0 : (wr && raddr_b == waddr) ? wdata : mem[raddr_b];
`else
  assign rd_a = raddr_a == '0 ? '0 : mem[raddr_a];
  assign rd_b = raddr_b == '0 ? '0 : mem[raddr_b];
`endif
  // Storage: writes to x0 are dropped, reset clears every entry.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    else if (wr)
      mem[waddr] <= wdata;
  // Read ports: each output updates only when its enable is set, otherwise holds.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (re_a) rdata_a <= rd_a;
      if (re_b) rdata_b <= rd_b;
    end
endmodule

// File: tb/tb_lx32_regfile.sv
// tb_lx32_regfile: randomized and directed checks of lx32_regfile against an array model.
module tb_lx32_regfile;
  logic        clk = 0, rst_n = 0, we = 0, re_a = 0, re_b = 0;
  logic [4:0]  waddr = 0, raddr_a = 0, raddr_b = 0;
  logic [31:0] wdata = 0, rdata_a, rdata_b;
  logic [31:0] model [32];
  logic [31:0] exp_a = 0, exp_b = 0;
  int vectors = 0, miscompares = 0;

  lx32_regfile dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [4:0] aa, input logic w,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (aa == 0) return 0;
`ifdef LX32_REGFILE_BYPASS_EN
    if (w && wa == aa) return wd;
`endif
    return model[aa];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 0;
    exp_a = 0;
    exp_b = 0;
  endtask

  task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ea, input logic [4:0] aa, input logic eb, input logic [4:0] ab);
    we = w; waddr = wa; wdata = wd; re_a = ea; raddr_a = aa; re_b = eb; raddr_b = ab;
    @(posedge clk);
    if (ea) exp_a = rd_model(aa, w, wa, wd);
    if (eb) exp_b = rd_model(ab, w, wa, wd);
    if (w && wa != 0) model[wa] = wd;
    @(negedge clk);
    chk("port_a", rdata_a, exp_a);
    chk("port_b", rdata_b, exp_b);
  endtask

  initial begin
    clear_model();
    #1;
    chk("rst_a", rdata_a, 0);
    chk("rst_b", rdata_b, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    step(0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 5, 1, 5);
    step(0, 0, 0, 1, 31, 1, 31);
    chk("rst_x31", rdata_a, 0);
    step(1, 7, 32'hA5A5A5A5, 0, 0, 0, 0);
    step(0, 0, 0, 1, 7, 0, 0);
    chk("wr_rd_x7", rdata_a, 32'hA5A5A5A5);
    step(1, 7, 32'hFFFFFFFF, 0, 7, 0, 0);
    chk("hold_x7", rdata_a, 32'hA5A5A5A5);
    step(1, 0, 32'hDEADBEEF, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    chk("x0_a", rdata_a, 0);
    chk("x0_b", rdata_b, 0);
    step(1, 3, 32'h11111111, 0, 0, 0, 0);
    step(1, 4, 32'h22222222, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 1, 4);
    chk("dual_a", rdata_a, 32'h11111111);
    chk("dual_b", rdata_b, 32'h22222222);
    step(0, 0, 0, 1, 4, 1, 4);
    chk("same_a", rdata_a, 32'h22222222);
    chk("same_b", rdata_b, 32'h22222222);
    step(1, 9, 32'h00000001, 0, 0, 0, 0);
    step(1, 9, 32'h00000002, 1, 9, 0, 0);
`ifdef LX32_REGFILE_BYPASS_EN
    chk("collide", rdata_a, 32'h00000002);
`else
    chk("collide", rdata_a, 32'h00000001);
`endif
    step(0, 0, 0, 1, 9, 0, 0);
    chk("after_collide", rdata_a, 32'h00000002);
    step(0, 12, 32'h12345678, 0, 0, 0, 0);
    step(0, 0, 0, 1, 12, 0, 0);
    chk("we_off_x12", rdata_a, 0);
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1), 5'($urandom_range(0, 7)),
           $urandom_range(0, 1), 5'($urandom_range(0, 31)));
    step(0, 0, 0, 1, 7, 1, 4);
    #2 rst_n = 0;
    clear_model();
    #1;
    chk("async_rst_a", rdata_a, 0);
    chk("async_rst_b", rdata_b, 0);
    @(negedge clk);
    rst_n = 1;
    step(0, 0, 0, 1, 7, 1, 4);
    step(0, 0, 0, 1, 3, 1, 9);
    chk("post_rst_x3", rdata_a, 0);
    for (int n = 0; n < 200; n++)
      step($urandom_range(0, 1), 5'($urandom), $urandom,
           $urandom_range(0, 1), 5'($urandom), $urandom_range(0, 1), 5'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
